// File: rtl/lut6_cfg_loader.sv
// Runtime-reloadable LUT6: a byte stream fills a shadow table, and a well-framed
// 8-byte load is committed atomically to the active table that drives o/o_q/lut_table.
module lut6_cfg_loader #(
  parameter logic [63:0] INIT = 64'h0000000000000000,
  parameter string       LOC  = "UNPLACED"
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  cfg_data,
  input  logic        cfg_valid,
  input  logic        cfg_last,
  output logic        cfg_ready,
  output logic        cfg_done,
  output logic        cfg_err,
  input  logic [5:0]  adr,
  output logic        o,
  output logic        o_q,
  output logic [63:0] lut_table
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  k_r;
  logic [2:0]  k_nxt_s;
  logic [63:0] shadow_r;
  logic [63:0] active_r;
  logic        o_q_r;
  logic        done_r;
  logic        err_r;
  logic        accept_s;
  logic        wr_s;
  logic        err_s;
  logic        commit_s;
  logic        o_s;

  // Ready drops during the commit cycle and is forced low while reset is asserted.
  assign cfg_ready = rstn & (state_r != COMMIT);
  assign accept_s  = cfg_valid & cfg_ready;
  assign o_s       = active_r[adr];

  assign o         = o_s;
  assign o_q       = o_q_r;
  assign cfg_done  = done_r;
  assign cfg_err   = err_r;
  assign lut_table = active_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and framing decode; any framing error clears the byte counter.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    wr_s        = 1'b0;
    err_s       = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (cfg_last) begin
            err_s   = 1'b1;
            k_nxt_s = 3'd0;
          end else begin
            wr_s        = 1'b1;
            k_nxt_s     = 3'd1;
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          if (k_r == 3'd7) begin
            if (cfg_last) begin
              wr_s        = 1'b1;
              k_nxt_s     = 3'd0;
              state_nxt_s = COMMIT;
            end else begin
              err_s       = 1'b1;
              k_nxt_s     = 3'd0;
              state_nxt_s = IDLE;
            end
          end else begin
            if (cfg_last) begin
              err_s       = 1'b1;
              k_nxt_s     = 3'd0;
              state_nxt_s = IDLE;
            end else begin
              wr_s    = 1'b1;
              k_nxt_s = k_r + 3'd1;
            end
          end
        end else begin
          state_nxt_s = LOAD;
        end
      end
      COMMIT: begin
        commit_s    = 1'b1;
        k_nxt_s     = 3'd0;
        state_nxt_s = IDLE;
      end
      default: begin
        k_nxt_s     = 3'd0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: byte counter, shadow fill, atomic commit, status pulses, registered lookup.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_r      <= 3'd0;
      shadow_r <= 64'd0;
      active_r <= INIT;
      o_q_r    <= INIT[0];
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      k_r    <= k_nxt_s;
      o_q_r  <= o_s;
      done_r <= commit_s;
      err_r  <= err_s;
      if (wr_s) begin
        shadow_r[{k_r, 3'b000} +: 8] <= cfg_data;
      end
      if (commit_s) begin
        active_r <= shadow_r;
      end
    end
  end

endmodule

// File: tb/tb_lut6_cfg_loader.sv
// Directed self-checking bench for lut6_cfg_loader with hand-computed expectations.
module tb_lut6_cfg_loader;

  localparam logic [63:0] INIT_V = 64'h8000000000000001;

  logic        clk;
  logic        rstn;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_last;
  logic        cfg_ready;
  logic        cfg_done;
  logic        cfg_err;
  logic [5:0]  adr;
  logic        o;
  logic        o_q;
  logic [63:0] lut_table;

  int compared   = 0;
  int mismatched = 0;

  lut6_cfg_loader #(.INIT(INIT_V), .LOC("UNPLACED")) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_last  (cfg_last),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .adr       (adr),
    .o         (o),
    .o_q       (o_q),
    .lut_table (lut_table)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte and return 1ns after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    while (!cfg_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cfg_ready) chk("ready_timeout", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Full 8-byte load; returns 1ns after the commit edge.
  task automatic load8(input string tag, input logic [63:0] v, input logic [63:0] old_tbl);
    for (int k = 0; k < 8; k++) send(v[8*k +: 8], (k == 7));
    chk({tag, "_rdy_commit"}, 64'(cfg_ready), 64'd0);
    chk({tag, "_tbl_pre"}, lut_table, old_tbl);
    chk({tag, "_done_pre"}, 64'(cfg_done), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done"}, 64'(cfg_done), 64'd1);
    chk({tag, "_err"}, 64'(cfg_err), 64'd0);
    chk({tag, "_tbl"}, lut_table, v);
  endtask

  initial begin
    rstn = 1'b0; cfg_valid = 1'b1; cfg_data = 8'h5A; cfg_last = 1'b0; adr = 6'd0;
    // Reset: ready held low even with valid asserted
    #1;
    chk("rst_ready_comb", 64'(cfg_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    chk("rst_table", lut_table, INIT_V);
    chk("rst_done", 64'(cfg_done), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    chk("rst_oq", 64'(o_q), 64'd1);
    cfg_valid = 1'b0;
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", 64'(cfg_ready), 64'd1);

    // Sweep: only addresses 0 and 63 hit a set bit
    for (int i = 0; i < 64; i++) begin
      adr = 6'(i);
      #1;
      chk("sweep_o", 64'(o), 64'(i == 0 || i == 63));
      @(posedge clk); #1;
      chk("sweep_oq", 64'(o_q), 64'(i == 0 || i == 63));
    end

    // Parity table
    adr = 6'd1;
    load8("par", 64'h6996966996696996, INIT_V);
    chk("par_o_new", 64'(o), 64'd1);
    chk("par_oq_old", 64'(o_q), 64'd0);
    @(posedge clk); #1;
    chk("par_oq_new", 64'(o_q), 64'd1);
    chk("par_done_pulse", 64'(cfg_done), 64'd0);
    for (int i = 0; i < 64; i++) begin
      adr = 6'(i);
      #1;
      chk("par_o", 64'(o), 64'(^(6'(i))));
    end

    // Gapped load with valid held through the commit cycle
    for (int k = 0; k < 8; k++) begin
      send(8'(k + 1), (k == 7));
      if (k != 7) begin
        repeat (2) @(posedge clk);
        #1;
        chk("gap_tbl_hold", lut_table, 64'h6996966996696996);
      end
    end
    cfg_valid = 1'b1; cfg_data = 8'hAA; cfg_last = 1'b1;
    #1;
    chk("gap_rdy_commit", 64'(cfg_ready), 64'd0);
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_last = 1'b0;
    chk("gap_done", 64'(cfg_done), 64'd1);
    chk("gap_tbl", lut_table, 64'h0807060504030201);
    @(posedge clk); #1;
    chk("gap_no_extra_err", 64'(cfg_err), 64'd0);
    chk("gap_done_pulse", 64'(cfg_done), 64'd0);

    // Short frame: LAST on byte 3
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("short_err_early", 64'(cfg_err), 64'd0);
    send(8'h33, 1'b1);
    chk("short_err", 64'(cfg_err), 64'd1);
    chk("short_done", 64'(cfg_done), 64'd0);
    chk("short_rdy", 64'(cfg_ready), 64'd1);
    chk("short_tbl", lut_table, 64'h0807060504030201);
    @(posedge clk); #1;
    chk("short_err_pulse", 64'(cfg_err), 64'd0);
    load8("ones", 64'hFFFFFFFFFFFFFFFF, 64'h0807060504030201);

    // Long frame: eight bytes without LAST, then a lone LAST byte
    for (int k = 0; k < 7; k++) send(8'(8'h40 + k), 1'b0);
    chk("long_err_early", 64'(cfg_err), 64'd0);
    send(8'h47, 1'b0);
    chk("long_err", 64'(cfg_err), 64'd1);
    chk("long_done", 64'(cfg_done), 64'd0);
    @(posedge clk); #1;
    chk("long_err_pulse", 64'(cfg_err), 64'd0);
    chk("long_no_commit", 64'(cfg_done), 64'd0);
    chk("long_tbl", lut_table, 64'hFFFFFFFFFFFFFFFF);
    send(8'h00, 1'b1);
    chk("lone_err", 64'(cfg_err), 64'd1);
    chk("lone_tbl", lut_table, 64'hFFFFFFFFFFFFFFFF);

    // Reset mid-load after byte 5
    for (int k = 0; k < 5; k++) send(8'(8'hC0 + k), 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(cfg_ready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("mid_rst_tbl", lut_table, INIT_V);
    chk("mid_rst_err", 64'(cfg_err), 64'd0);
    chk("mid_rst_done", 64'(cfg_done), 64'd0);
    @(posedge clk); #1;
    chk("mid_rst_err2", 64'(cfg_err), 64'd0);
    chk("mid_rst_done2", 64'(cfg_done), 64'd0);
    load8("after_rst", 64'h0123456789ABCDEF, INIT_V);
    adr = 6'd0;
    #1;
    chk("after_rst_o0", 64'(o), 64'd1);
    adr = 6'd4;
    #1;
    chk("after_rst_o4", 64'(o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
